// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// master = fetch side (drives req/addr), slave = memory side (drives ack/rdata).
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, fetches over a req/ack bus and loads IF/ID. IF/ID loads the cycle after ack.
// Decode stall parks one response in a skid buffer (imem_req drops); EX redirects flush IF/ID and kill fetches.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  input  logic               StallD,
  fetch_ctrl_if.master       imem,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD,
  output logic               fetch_err
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_KILL,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;
  logic [31:0] instr_q;
  logic [31:0] pcd_q;
  logic [31:0] pcp4_q;
  logic        validd_q;
  logic [TCW-1:0] tcnt_q;

  logic [TCW-1:0] tcnt_d;
  logic [31:0]    tgt_d;
  logic [31:0]    next_addr_d;
  logic [31:0]    buf_pcp4_d;
  logic           slot_free_d;
  logic           timeout_d;

  always_comb begin
    tgt_d       = {PCTargetE[31:2], 2'b00};
    next_addr_d = req_addr_q + 32'd4;
    buf_pcp4_d  = buf_pc_q + 32'd4;
    slot_free_d = !validd_q || !StallD;
    tcnt_d      = tcnt_q + 1'b1;
    timeout_d   = (tcnt_d == TCW'(TIMEOUT));
  end

  assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_KILL);
  assign imem.imem_addr = req_addr_q;
  assign InstrD         = instr_q;
  assign PCD            = pcd_q;
  assign PCPlus4D       = pcp4_q;
  assign ValidD         = validd_q;
  assign fetch_err      = (state_q == S_ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      instr_q     <= 32'd0;
      pcd_q       <= 32'd0;
      pcp4_q      <= 32'd0;
      validd_q    <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      // Bubble unless decode is holding a real instruction; a redirect always flushes.
      if (state_q != S_ERR && (PCSrcE || !(StallD && validd_q))) begin
        validd_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          tcnt_q  <= '0;
          if (PCSrcE) begin
            pc_q       <= tgt_d;
            req_addr_q <= tgt_d;
          end else begin
            req_addr_q <= pc_q;
          end
        end

        S_REQ: begin
          if (imem.imem_ack) begin
            tcnt_q <= '0;
            if (PCSrcE) begin
              pc_q       <= tgt_d;
              req_addr_q <= tgt_d;
            end else if (slot_free_d) begin
              instr_q    <= imem.imem_rdata;
              pcd_q      <= req_addr_q;
              pcp4_q     <= next_addr_d;
              validd_q   <= 1'b1;
              pc_q       <= next_addr_d;
              req_addr_q <= next_addr_d;
            end else begin
              buf_instr_q <= imem.imem_rdata;
              buf_pc_q    <= req_addr_q;
              pc_q        <= next_addr_d;
              state_q     <= S_HOLD;
            end
          end else if (timeout_d) begin
            state_q <= S_ERR;
            tcnt_q  <= '0;
          end else if (PCSrcE) begin
            pc_q    <= tgt_d;
            state_q <= S_KILL;
            tcnt_q  <= '0;
          end else begin
            tcnt_q <= tcnt_d;
          end
        end

        S_KILL: begin
          // The stale request stays on the bus until memory answers; its data is discarded.
          if (imem.imem_ack) begin
            tcnt_q  <= '0;
            state_q <= S_REQ;
            if (PCSrcE) begin
              pc_q       <= tgt_d;
              req_addr_q <= tgt_d;
            end else begin
              req_addr_q <= pc_q;
            end
          end else if (timeout_d) begin
            state_q <= S_ERR;
            tcnt_q  <= '0;
          end else begin
            tcnt_q <= tcnt_d;
            if (PCSrcE) begin
              pc_q <= tgt_d;
            end
          end
        end

        S_HOLD: begin
          if (PCSrcE) begin
            pc_q       <= tgt_d;
            req_addr_q <= tgt_d;
            state_q    <= S_REQ;
          end else if (!StallD) begin
            instr_q    <= buf_instr_q;
            pcd_q      <= buf_pc_q;
            pcp4_q     <= buf_pcp4_d;
            validd_q   <= 1'b1;
            req_addr_q <= pc_q;
            state_q    <= S_REQ;
          end
        end

        S_ERR: begin
          state_q <= S_ERR;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: variable-latency memory model plus an instruction-stream reference
// (next delivered PC is previous+4, or the aligned target after a redirect).
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        fetch_err;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallD    (StallD),
    .imem      (bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // stimulus controls
  logic        rst_v = 1'b0;
  logic        stall_v = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] tgt_v = 32'd0;
  int          mem_lat = 1;     // 0 = never acknowledge
  bit          rand_lat = 1'b0;
  int          wait_cnt = 0;
  int          cur_lat = 1;

  // inputs applied during the previous cycle, outputs seen at the previous sample
  logic        p_rst = 1'b0, p_stall = 1'b0, p_redir = 1'b0, p_ack = 1'b0;
  logic [31:0] p_tgt = 32'd0;
  logic        po_req = 1'b0, po_vld = 1'b0;
  logic [31:0] po_addr = 32'd0, po_instr = 32'd0, po_pcd = 32'd0;

  logic [31:0] exp_next = 32'd0;
  bit          new_dlv = 1'b0;
  int          ndlv = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    rst       = rst_v;
    StallD    = stall_v;
    PCSrcE    = redir_v;
    PCTargetE = tgt_v;
    if (rst_v && bus.imem_req) begin
      if (wait_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      wait_cnt++;
      if (cur_lat > 0 && wait_cnt >= cur_lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memfn(bus.imem_addr);
        wait_cnt       = 0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
      end
    end else begin
      bus.imem_ack = 1'b0;
      wait_cnt     = 0;
    end
    p_rst   = rst_v;
    p_stall = stall_v;
    p_redir = redir_v;
    p_tgt   = tgt_v;
    p_ack   = bus.imem_ack;
  endtask

  // Per-cycle comparison against the instruction-stream reference.
  task automatic sample_check();
    @(negedge clk);
    new_dlv = 1'b0;
    if (!p_rst || !rst) begin
      chk("reset_validd", {31'd0, ValidD}, 32'd0);
      chk("reset_req", {31'd0, bus.imem_req}, 32'd0);
      exp_next = 32'h0000_0000;
    end else begin
      if (bus.imem_req) chk("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
      if (po_req && !p_ack && bus.imem_req) chk("addr_stable", bus.imem_addr, po_addr);
      if (!fetch_err) begin
        if (p_redir) begin
          chk("flush_validd", {31'd0, ValidD}, 32'd0);
          exp_next = {p_tgt[31:2], 2'b00};
        end else if (po_vld && p_stall) begin
          chk("hold_validd", {31'd0, ValidD}, 32'd1);
          chk("hold_instr", InstrD, po_instr);
          chk("hold_pcd", PCD, po_pcd);
        end else if (ValidD) begin
          chk("seq_pcd", PCD, exp_next);
          chk("seq_instr", InstrD, memfn(PCD));
          chk("seq_pcplus4", PCPlus4D, PCD + 32'd4);
          exp_next = PCD + 32'd4;
          new_dlv  = 1'b1;
          ndlv++;
        end
      end
    end
    po_req   = bus.imem_req;
    po_addr  = bus.imem_addr;
    po_vld   = ValidD;
    po_instr = InstrD;
    po_pcd   = PCD;
  endtask

  task automatic step();
    drive();
    sample_check();
  endtask

  task automatic do_reset();
    rst_v   = 1'b0;
    stall_v = 1'b0;
    redir_v = 1'b0;
    repeat (2) step();
    rst_v = 1'b1;
  endtask

  task automatic wait_dlv(input int maxc, output logic [31:0] pc, output logic [31:0] p4);
    bit ok;
    ok = 1'b0;
    pc = 32'd0;
    p4 = 32'd0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (new_dlv) begin
        pc = PCD;
        p4 = PCPlus4D;
        ok = 1'b1;
        break;
      end
    end
    chk("wait_delivery", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc, p4, held;
    logic [31:0] t1_pc [4];
    int          t1_cyc [4];
    int          cyc, n, cnt0, c0, c1, t1n, rnd_start;
    logic        vld_after;

    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0; StallD = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;

    // Reset values
    do_reset();
    chk("rst_instr", InstrD, 32'd0);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcplus4", PCPlus4D, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);

    // 1: ack tied high, back-to-back delivery
    mem_lat = 1; rand_lat = 1'b0;
    t1n = 0;
    for (int i = 0; i < 12 && t1n < 4; i++) begin
      step();
      if (new_dlv) begin
        t1_pc[t1n]  = PCD;
        t1_cyc[t1n] = i;
        t1n++;
      end
    end
    chk("t1_count", t1n, 4);
    chk("t1_pc0", t1_pc[0], 32'h0);
    chk("t1_pc1", t1_pc[1], 32'h4);
    chk("t1_pc2", t1_pc[2], 32'h8);
    chk("t1_pc3", t1_pc[3], 32'hC);
    chk("t1_first_cycle", t1_cyc[0], 1);
    chk("t1_consecutive", t1_cyc[3] - t1_cyc[0], 3);

    // 2: 3-cycle ack latency
    do_reset();
    mem_lat = 3;
    cnt0 = 0; n = 0; c0 = 0; c1 = 0; vld_after = 1'b1;
    for (cyc = 0; cyc < 40 && n < 2; cyc++) begin
      step();
      if (bus.imem_req && bus.imem_addr == 32'h0) cnt0++;
      if (n == 1 && cyc == c0 + 1) vld_after = ValidD;
      if (new_dlv) begin
        if (n == 0) begin c0 = cyc; chk("t2_pc0", PCD, 32'h0); end
        else begin c1 = cyc; chk("t2_pc1", PCD, 32'h4); end
        n++;
      end
    end
    chk("t2_addr0_cycles", cnt0, 3);
    chk("t2_spacing", c1 - c0, 3);
    chk("t2_validd_pulse", {31'd0, vld_after}, 32'd0);

    // 4: redirect while fetch of 0x8 is outstanding -> KILL
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h8 && wait_cnt == 0) begin n = 1; break; end
      step();
    end
    chk("t4_reach_0x8", n, 1);
    redir_v = 1'b1; tgt_v = 32'h100;
    step();
    redir_v = 1'b0;
    chk("t4_kill_addr", bus.imem_addr, 32'h8);
    wait_dlv(30, pc, p4);
    chk("t4_next_pc", pc, 32'h100);

    // 5: unaligned target and PC wrap
    mem_lat = 1;
    repeat (8) step();
    redir_v = 1'b1; tgt_v = 32'h103;
    step();
    redir_v = 1'b0;
    chk("t5_align_addr", bus.imem_addr, 32'h100);
    wait_dlv(10, pc, p4);
    chk("t5_pc", pc, 32'h100);
    redir_v = 1'b1; tgt_v = 32'hFFFF_FFFE;
    step();
    redir_v = 1'b0;
    wait_dlv(10, pc, p4);
    chk("t5_wrap_pc", pc, 32'hFFFF_FFFC);
    chk("t5_wrap_pcplus4", p4, 32'h0);
    wait_dlv(10, pc, p4);
    chk("t5_after_wrap", pc, 32'h0);

    // 3: 4-cycle decode stall with ack tied high
    repeat (4) step();
    held = 32'd0;
    stall_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_req_low", {31'd0, bus.imem_req}, 32'd0);
      held = PCD;
    end
    stall_v = 1'b0;
    wait_dlv(10, pc, p4);
    chk("t3_resume_pc", pc, held + 32'd4);
    wait_dlv(10, pc, p4);
    chk("t3_resume_pc2", pc, held + 32'd8);

    // 6: memory never answers
    do_reset();
    mem_lat = 0;
    cnt0 = 0; n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fetch_err) begin n = 1; break; end
      if (bus.imem_req) cnt0++;
    end
    chk("t6_err_seen", n, 1);
    chk("t6_req_cycles", cnt0, 16);
    chk("t6_req_low", {31'd0, bus.imem_req}, 32'd0);
    repeat (3) step();
    chk("t6_err_sticky", {31'd0, fetch_err}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_err", {31'd0, fetch_err}, 32'd0);
    chk("t6_async_req", {31'd0, bus.imem_req}, 32'd0);
    do_reset();
    mem_lat = 1;
    wait_dlv(10, pc, p4);
    chk("t6_restart_pc", pc, 32'h0);

    // Randomized traffic: latency 1..4, stalls, redirects
    do_reset();
    rand_lat  = 1'b1;
    rnd_start = ndlv;
    for (int i = 0; i < 3000; i++) begin
      stall_v = ($urandom_range(0, 99) < 30);
      redir_v = ($urandom_range(0, 99) < 5);
      tgt_v   = $urandom & 32'h0000_0FFF;
      step();
    end
    stall_v = 1'b0;
    redir_v = 1'b0;
    repeat (4) step();
    chk("rand_progress", {31'd0, (ndlv - rnd_start) >= 200}, 32'd1);
    chk("rand_no_err", {31'd0, fetch_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
